block_lr_48: RTL and testbench

- Stereo matrix decoder: the inverse of the L+R / L−R mixing stage. Takes a gain-scaled sum (LpR) and difference (LmR) sample pair and reconstructs LEFT and RIGHT at the 48 kHz sample rate.
- Each channel gain is applied with an internal shift-add sequential multiplier, one gain bit per clock.
- Samples enter and leave through valid/ready handshakes.
- Used in the loopback/verification path and in the receiver-side demo datapath.

---
 rtl/block_lr_48.sv | 129 ++++++++++++
 tb/tb_block_lr_48.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_lr_48.sv
// Stereo matrix decoder: rebuilds LEFT/RIGHT from gain-scaled L+R / L-R using shift-add multipliers.
// Optional macro DECODER_SAT_EN: saturate the N-bit output reduction instead of wrapping.
module block_lr_48 #(
    parameter int N    = 18,
    parameter int M    = 4,
    parameter int FRAC = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic signed [N-1:0] LpR_in,
    input  logic signed [N-1:0] LmR_in,
    input  logic        [M-1:0] Gs,
    input  logic        [M-1:0] Gd,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [N-1:0] LEFT,
    output logic signed [N-1:0] RIGHT,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int ACC_W = N + M;
    localparam int SUM_W = N + M + 1;
    localparam int CW    = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, MUL, COMB, HOLD} state_t;

    state_t                    r_state, w_next;
    logic signed [N-1:0]       r_lpr, r_lmr;
    logic        [M-1:0]       r_gs, r_gd;
    logic        [CW-1:0]      r_cnt;
    logic signed [ACC_W-1:0]   r_acc_s, r_acc_d;
    logic signed [N-1:0]       r_left, r_right;

    logic signed [ACC_W-1:0]   w_lpr_ext, w_lmr_ext;
    logic signed [SUM_W-1:0]   w_s_ext, w_d_ext, w_sum, w_dif, w_sum_sh, w_dif_sh;

    function automatic logic signed [N-1:0] reduce(input logic signed [SUM_W-1:0] v);
`ifdef DECODER_SAT_EN
        logic signed [SUM_W-1:0] sat_max;
        logic signed [SUM_W-1:0] sat_min;
        sat_max = SUM_W'((2 ** (N - 1)) - 1);
        sat_min = SUM_W'(-(2 ** (N - 1)));
        if (v > sat_max)
            return N'(sat_max);
        else if (v < sat_min)
            return N'(sat_min);
        else
            return N'(v);
`else
        return N'(v);
`endif
    endfunction

    assign w_lpr_ext = {{M{r_lpr[N-1]}}, r_lpr};
    assign w_lmr_ext = {{M{r_lmr[N-1]}}, r_lmr};
    assign w_s_ext   = {r_acc_s[ACC_W-1], r_acc_s};
    assign w_d_ext   = {r_acc_d[ACC_W-1], r_acc_d};
    assign w_sum     = w_s_ext + w_d_ext;
    assign w_dif     = w_s_ext - w_d_ext;
    // Arithmetic shift floors toward minus infinity; the extra bit halves the L+R/L-R doubling.
    assign w_sum_sh  = w_sum >>> (FRAC + 1);
    assign w_dif_sh  = w_dif >>> (FRAC + 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = MUL;
            MUL:     if (r_cnt == CW'(M - 1)) w_next = COMB;
            COMB:    w_next = HOLD;
            HOLD:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lpr   <= '0;
            r_lmr   <= '0;
            r_gs    <= '0;
            r_gd    <= '0;
            r_cnt   <= '0;
            r_acc_s <= '0;
            r_acc_d <= '0;
            r_left  <= '0;
            r_right <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_lpr   <= LpR_in;
                        r_lmr   <= LmR_in;
                        r_gs    <= Gs;
                        r_gd    <= Gd;
                        r_cnt   <= '0;
                        r_acc_s <= '0;
                        r_acc_d <= '0;
                    end
                end
                MUL: begin
                    if (r_gs[r_cnt])
                        r_acc_s <= r_acc_s + (w_lpr_ext <<< r_cnt);
                    if (r_gd[r_cnt])
                        r_acc_d <= r_acc_d + (w_lmr_ext <<< r_cnt);
                    r_cnt <= r_cnt + CW'(1);
                end
                COMB: begin
                    r_left  <= reduce(w_sum_sh);
                    r_right <= reduce(w_dif_sh);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);
    assign LEFT      = r_left;
    assign RIGHT     = r_right;

endmodule

// File: tb/tb_block_lr_48.sv
// Directed self-checking bench for block_lr_48 (default parameters N=18, M=4, FRAC=3).
module tb_block_lr_48;

    logic               clock;
    logic               reset;
    logic signed [17:0] lpr, lmr;
    logic        [3:0]  gs, gd;
    logic               in_valid, in_ready;
    logic signed [17:0] left, right;
    logic               out_valid, out_ready;

    int checks = 0;
    int errors = 0;

    int b_lpr [3] = '{1000, 5000, -1000};
    int b_lmr [3] = '{200, -3000, 200};
    int b_g   [3] = '{8, 0, 8};
    int b_l   [3] = '{600, 0, -400};
    int b_r   [3] = '{400, 0, -600};

    block_lr_48 dut (
        .clock    (clock),
        .reset    (reset),
        .LpR_in   (lpr),
        .LmR_in   (lmr),
        .Gs       (gs),
        .Gd       (gd),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .LEFT     (left),
        .RIGHT    (right),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int lpr_v, input int lmr_v, input int gs_v, input int gd_v);
        lpr = 18'(lpr_v);
        lmr = 18'(lmr_v);
        gs  = 4'(gs_v);
        gd  = 4'(gd_v);
    endtask

    task automatic run_pair(input string tag, input int lpr_v, input int lmr_v,
                            input int gs_v, input int gd_v, input int exp_l, input int exp_r);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 1);
        drive(lpr_v, lmr_v, gs_v, gd_v);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        drive(-77777, 12345, 15, 5);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 20);
        check({tag, " latency"}, n, 5);
        check({tag, " LEFT"}, left, exp_l);
        check({tag, " RIGHT"}, right, exp_r);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid), 0);
    endtask

    initial begin
        int n;
        int idx;
        int outs;
        int last_cyc;
        logic acc_now;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(0, 0, 0, 0);
        #12;
        check("rst in_ready", 32'(in_ready), 1);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst LEFT", left, 0);
        check("rst RIGHT", right, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();

        run_pair("unity", 1000, 200, 8, 8, 600, 400);
        run_pair("neg", -1000, 200, 8, 8, -400, -600);
        run_pair("floor", -1, 0, 8, 8, -1, -1);
`ifdef DECODER_SAT_EN
        run_pair("ovf", 131071, 131071, 15, 15, 131071, 0);
`else
        run_pair("ovf", 131071, 131071, 15, 15, -16386, 0);
`endif
        run_pair("mixgain", 2000, -400, 4, 12, 200, 800);

        // Backpressure: output held while out_ready is low, and a stray in_valid is ignored.
        drive(1000, 200, 8, 8);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            check("bp out_valid", 32'(out_valid), 1);
            check("bp in_ready", 32'(in_ready), 0);
            check("bp LEFT", left, 600);
            check("bp RIGHT", right, 400);
            if (i == 1) begin
                drive(7000, 0, 8, 8);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        check("bp still valid", 32'(out_valid), 1);
        check("bp still LEFT", left, 600);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release valid", 32'(out_valid), 0);
        check("bp release ready", 32'(in_ready), 1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid || !in_ready) n++;
            tick();
        end
        check("bp pulse not accepted", n, 0);

        // Back-to-back with in_valid and out_ready held high.
        idx      = 0;
        outs     = 0;
        last_cyc = -1;
        out_ready = 1'b1;
        drive(b_lpr[0], b_lmr[0], b_g[0], b_g[0]);
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            acc_now = in_ready && in_valid;
            tick();
            if (acc_now) begin
                idx++;
                if (idx < 3)
                    drive(b_lpr[idx], b_lmr[idx], b_g[idx], b_g[idx]);
                else
                    in_valid = 1'b0;
            end
            if (out_valid) begin
                if (outs < 3) begin
                    check($sformatf("b2b%0d LEFT", outs), left, b_l[outs]);
                    check($sformatf("b2b%0d RIGHT", outs), right, b_r[outs]);
                end
                if (outs > 0)
                    check($sformatf("b2b%0d spacing", outs), c - last_cyc, 7);
                last_cyc = c;
                outs++;
            end
        end
        check("b2b output count", outs, 3);
        out_ready = 1'b0;
        in_valid  = 1'b0;

        // Reset two cycles into the multiply aborts the sample.
        drive(3000, 1000, 8, 8);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("mid rst in_ready", 32'(in_ready), 1);
        check("mid rst out_valid", 32'(out_valid), 0);
        check("mid rst LEFT", left, 0);
        check("mid rst RIGHT", right, 0);
        #10;
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) n++;
            tick();
        end
        check("mid rst no output", n, 0);
        run_pair("post rst", 2000, -400, 4, 12, 200, 800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
